timer_multicanal: RTL and testbench

//  Parametrised multi-channel programmable timer, successor to the fixed 1 s timer.

---
 rtl/timer_pkg.sv | 15 +
 rtl/timer_multicanal_if.sv | 36 +++
 rtl/timer_canal.sv | 108 ++++++++++
 rtl/timer_multicanal.sv | 67 ++++++
 tb/tb_timer_multicanal.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared types and helpers for the multi-channel timer.
// Holds the channel state encoding and the pulse-stretcher width function.
package timer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } canal_state_t;

  // Bits needed to hold the value cyc (at least one bit).
  function automatic int pulse_w(input int cyc);
    return (cyc < 2) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/timer_multicanal_if.sv
// Control/status bundle of timer_multicanal; channel i of limite/cuenta lives in [i*CNT_W +: CNT_W].
// master = controlling side, slave = timer side.
interface timer_multicanal_if #(
  parameter int N_CH  = 2,
  parameter int CNT_W = 27
);

  logic [N_CH-1:0]       start;
  logic [N_CH-1:0]       stop;
  logic [N_CH-1:0]       periodico;
  logic [N_CH*CNT_W-1:0] limite;
  logic [N_CH-1:0]       termino;
  logic [N_CH-1:0]       ocupado;
  logic [N_CH*CNT_W-1:0] cuenta;

  modport master (
    output start,
    output stop,
    output periodico,
    output limite,
    input  termino,
    input  ocupado,
    input  cuenta
  );

  modport slave (
    input  start,
    input  stop,
    input  periodico,
    input  limite,
    output termino,
    output ocupado,
    output cuenta
  );

endinterface

// File: rtl/timer_canal.sv
// One timer channel: IDLE/COUNT FSM, tick counter with terminal-count compare,
// and a clk-driven stretcher that holds termino high for PULSE_CYC cycles.
//
// state | meaning
// IDLE  | waiting for start, cuenta held at 0
// COUNT | advancing cuenta on each tick until latched limit-1
module timer_canal
  import timer_pkg::*;
#(
  parameter int CNT_W     = 27,
  parameter int PULSE_CYC = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodico,
  input  logic [CNT_W-1:0] limite,
  output logic             termino,
  output logic             ocupado,
  output logic [CNT_W-1:0] cuenta
);

  localparam int               PW     = pulse_w(PULSE_CYC);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
  localparam logic [PW-1:0]    P_ONE  = PW'(1);
  localparam logic [PW-1:0]    P_LOAD = PW'(PULSE_CYC);

  canal_state_t     state_q;
  canal_state_t     state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] lim_q;
  logic [CNT_W-1:0] lim_d;
  logic             per_q;
  logic             per_d;
  logic [PW-1:0]    pcnt_q;
  logic [PW-1:0]    pcnt_d;
  logic             hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lim_q   <= C_ONE;
      per_q   <= 1'b0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lim_q   <= lim_d;
      per_q   <= per_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lim_d   = lim_q;
    per_d   = per_q;
    hit     = 1'b0;
    pcnt_d  = (pcnt_q != '0) ? (pcnt_q - P_ONE) : '0;

    case (state_q)
      IDLE: begin
        // stop has priority, so start+stop in the same cycle leaves the channel idle
        if (!stop && start) begin
          lim_d   = (limite == '0) ? C_ONE : limite;
          per_d   = periodico;
          cnt_d   = '0;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (stop) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (tick) begin
          if (cnt_q == (lim_q - C_ONE)) begin
            hit   = 1'b1;
            cnt_d = '0;
            if (!per_q) begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + C_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A new terminal count while the pulse is active restarts the full width
    if (hit) begin
      pcnt_d = P_LOAD;
    end
  end

  assign termino = (pcnt_q != '0);
  assign ocupado = (state_q == COUNT);
  assign cuenta  = cnt_q;

endmodule

// File: rtl/timer_multicanal.sv
// N_CH independent programmable timers sharing one tick source.
// Define TIMER_PRESC_EN to insert a free-running divide-by-PRESC tick; otherwise tick is every clk.
module timer_multicanal
  import timer_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int CNT_W     = 27,
  parameter int PULSE_CYC = 3,
  parameter int PRESC     = 100
) (
  input  logic               clk,
  input  logic               reset,
  timer_multicanal_if.slave  bus
);

  if (PULSE_CYC < 1) begin : g_pulse_chk
    $error("PULSE_CYC must be >= 1");
  end

  if (PRESC < 1) begin : g_presc_chk
    $error("PRESC must be >= 1");
  end

  logic tick;

`ifdef TIMER_PRESC_EN
  localparam int            DW       = (PRESC < 2) ? 1 : $clog2(PRESC);
  localparam logic [DW-1:0] DIV_LAST = DW'(PRESC - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  logic [DW-1:0] div_q;

  // Free-running from reset; channel starts do not realign the phase
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q <= '0;
    end else if (div_q == DIV_LAST) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + DIV_ONE;
    end
  end

  assign tick = (div_q == DIV_LAST);
`else
  assign tick = 1'b1;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_canal #(
      .CNT_W     (CNT_W),
      .PULSE_CYC (PULSE_CYC)
    ) u_canal (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .start     (bus.start[i]),
      .stop      (bus.stop[i]),
      .periodico (bus.periodico[i]),
      .limite    (bus.limite[i*CNT_W +: CNT_W]),
      .termino   (bus.termino[i]),
      .ocupado   (bus.ocupado[i]),
      .cuenta    (bus.cuenta[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_timer_multicanal.sv
// Directed bench for timer_multicanal: inputs change and outputs are sampled on the falling edge.
// k counts rising edges after the edge E that sampled start (k=0 is just after E).
module tb_timer_multicanal;

  localparam int N_CH      = 2;
  localparam int CNT_W     = 27;
  localparam int PULSE_CYC = 3;
  localparam int PRESC     = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;

  timer_multicanal_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  timer_multicanal #(
    .N_CH      (N_CH),
    .CNT_W     (CNT_W),
    .PULSE_CYC (PULSE_CYC),
    .PRESC     (PRESC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [CNT_W-1:0] cnt_of(input int ch);
    return bus.cuenta[ch*CNT_W +: CNT_W];
  endfunction

  task automatic set_lim(input int ch, input logic [CNT_W-1:0] val);
    bus.limite[ch*CNT_W +: CNT_W] = val;
  endtask

  task automatic test_reset();
    bus.start = '0;
    bus.stop = '0;
    bus.periodico = '0;
    bus.limite = '0;
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.termino !== 2'b00 || bus.ocupado !== 2'b00 || bus.cuenta !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs termino=%b ocupado=%b cuenta=%h want all zero",
               bus.termino, bus.ocupado, bus.cuenta);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.ocupado !== 2'b00 || bus.termino !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_release ocupado=%b termino=%b want 00 00", bus.ocupado, bus.termino);
    end
  endtask

  task automatic test_one_shot();
    logic             et, eo;
    logic [CNT_W-1:0] ec;
    set_lim(0, 27'd10);
    bus.periodico[0] = 1'b0;
    bus.start[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      et = (k >= 10 && k <= 12);
      eo = (k < 10);
      ec = (k < 10) ? CNT_W'(k) : '0;
      vectors++;
      if (bus.termino[0] !== et || bus.ocupado[0] !== eo || cnt_of(0) !== ec) begin
        miscompares++;
        $display("FAIL one_shot k=%0d termino=%b ocupado=%b cuenta=%0d want %b %b %0d",
                 k, bus.termino[0], bus.ocupado[0], cnt_of(0), et, eo, ec);
      end
      // a start while counting must not retrigger or relatch the limit
      if (k == 5) begin
        bus.start[0] = 1'b1;
        set_lim(0, 27'd3);
      end else begin
        bus.start[0] = 1'b0;
      end
    end
  endtask

  task automatic test_periodic();
    logic             et;
    logic [CNT_W-1:0] ec;
    set_lim(1, 27'd5);
    bus.periodico[1] = 1'b1;
    bus.start[1] = 1'b1;
    @(negedge clk);
    bus.start[1] = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      et = (k >= 5) && (((k - 5) % 5) < 3);
      ec = CNT_W'(k % 5);
      vectors++;
      if (bus.termino[1] !== et || bus.ocupado[1] !== 1'b1 || cnt_of(1) !== ec
          || bus.ocupado[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL periodic k=%0d termino=%b ocupado=%b cuenta=%0d ch0_ocupado=%b want %b 1 %0d 0",
                 k, bus.termino[1], bus.ocupado[1], cnt_of(1), bus.ocupado[0], et, ec);
      end
    end
    bus.stop[1] = 1'b1;
    @(negedge clk);
    bus.stop[1] = 1'b0;
    bus.periodico[1] = 1'b0;
    vectors++;
    if (bus.ocupado[1] !== 1'b0 || cnt_of(1) !== '0 || bus.termino[1] !== 1'b1) begin
      miscompares++;
      $display("FAIL periodic_stop ocupado=%b cuenta=%0d termino=%b want 0 0 1",
               bus.ocupado[1], cnt_of(1), bus.termino[1]);
    end
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.termino[1] !== 1'b0) begin
      miscompares++;
      $display("FAIL periodic_pulse_end termino=%b want 0", bus.termino[1]);
    end
  endtask

  task automatic test_abort();
    set_lim(0, 27'd20);
    bus.periodico[0] = 1'b0;
    bus.start[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    repeat (7) @(negedge clk);
    vectors++;
    if (cnt_of(0) !== 27'd7) begin
      miscompares++;
      $display("FAIL abort_precount cuenta=%0d want 7", cnt_of(0));
    end
    bus.stop[0] = 1'b1;
    @(negedge clk);
    bus.stop[0] = 1'b0;
    vectors++;
    if (cnt_of(0) !== '0 || bus.ocupado[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_stop cuenta=%0d ocupado=%b want 0 0", cnt_of(0), bus.ocupado[0]);
    end
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.termino[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_no_pulse k=%0d termino=%b want 0", k, bus.termino[0]);
      end
    end
    bus.start[0] = 1'b1;
    bus.stop[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    bus.stop[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (bus.ocupado[0] !== 1'b0 || bus.termino[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL start_stop_same k=%0d ocupado=%b termino=%b want 0 0",
                 k, bus.ocupado[0], bus.termino[0]);
      end
    end
  endtask

  task automatic test_edge_limits();
    logic [CNT_W-1:0] lv;
    for (int v = 0; v <= 1; v++) begin
      lv = CNT_W'(v);
      set_lim(0, lv);
      bus.periodico[0] = 1'b0;
      bus.start[0] = 1'b1;
      @(negedge clk);
      bus.start[0] = 1'b0;
      vectors++;
      if (bus.termino[0] !== 1'b0 || bus.ocupado[0] !== 1'b1) begin
        miscompares++;
        $display("FAIL edge_lim%0d_k0 termino=%b ocupado=%b want 0 1", v, bus.termino[0], bus.ocupado[0]);
      end
      @(negedge clk);
      vectors++;
      if (bus.termino[0] !== 1'b1 || bus.ocupado[0] !== 1'b0 || cnt_of(0) !== '0) begin
        miscompares++;
        $display("FAIL edge_lim%0d_k1 termino=%b ocupado=%b cuenta=%0d want 1 0 0",
                 v, bus.termino[0], bus.ocupado[0], cnt_of(0));
      end
      repeat (4) @(negedge clk);
    end
    set_lim(0, 27'd2);
    bus.periodico[0] = 1'b1;
    bus.start[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (bus.termino[0] !== (k >= 2)) begin
        miscompares++;
        $display("FAIL periodic_lim2 k=%0d termino=%b want %b", k, bus.termino[0], (k >= 2));
      end
    end
    bus.stop[0] = 1'b1;
    @(negedge clk);
    bus.stop[0] = 1'b0;
    bus.periodico[0] = 1'b0;
    for (int k = 21; k <= 23; k++) begin
      if (k > 21) @(negedge clk);
      vectors++;
      if (bus.termino[0] !== (k <= 22) || bus.ocupado[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL lim2_stop_tail k=%0d termino=%b ocupado=%b want %b 0",
                 k, bus.termino[0], bus.ocupado[0], (k <= 22));
      end
    end
  endtask

  task automatic test_back_to_back();
    set_lim(0, 27'd1);
    bus.periodico[0] = 1'b0;
    bus.start[0] = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 11; k++) begin
      if (k > 0) @(negedge clk);
      vectors++;
      if (bus.ocupado[0] !== (k <= 7 && (k % 2) == 0) || bus.termino[0] !== (k >= 1 && k <= 9)) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d ocupado=%b termino=%b want %b %b", k, bus.ocupado[0],
                 bus.termino[0], (k <= 7 && (k % 2) == 0), (k >= 1 && k <= 9));
      end
      if (k == 7) bus.start[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    set_lim(0, 27'd10);
    set_lim(1, 27'd3);
    bus.periodico = 2'b10;
    bus.start = 2'b11;
    @(negedge clk);
    bus.start = 2'b00;
    repeat (4) @(negedge clk);
    vectors++;
    if (bus.termino !== 2'b10 || bus.ocupado !== 2'b11 || cnt_of(0) !== 27'd4) begin
      miscompares++;
      $display("FAIL reset_mid_pre termino=%b ocupado=%b cuenta0=%0d want 10 11 4",
               bus.termino, bus.ocupado, cnt_of(0));
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (bus.termino !== 2'b00 || bus.ocupado !== 2'b00 || bus.cuenta !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async termino=%b ocupado=%b cuenta=%h want all zero",
               bus.termino, bus.ocupado, bus.cuenta);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus.periodico = 2'b00;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      vectors++;
      if (bus.termino !== 2'b00 || bus.ocupado !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_mid_after k=%0d termino=%b ocupado=%b want 00 00", k, bus.termino, bus.ocupado);
      end
    end
  endtask

  task automatic test_presc();
    int  lat;
    logic seen;
    lat  = -1;
    seen = 1'b0;
    set_lim(0, 27'd3);
    bus.periodico[0] = 1'b0;
    bus.start[0] = 1'b1;
    @(negedge clk);
    bus.start[0] = 1'b0;
    for (int k = 1; k <= 30 && !seen; k++) begin
      @(negedge clk);
      bus.start[0] = (k == 2);
      if (bus.termino[0] === 1'b1) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    bus.start[0] = 1'b0;
    // three ticks of a divide-by-4 prescaler land between 9 and 15 edges after start
    vectors++;
    if (!seen || lat < 9 || lat > 15) begin
      miscompares++;
      $display("FAIL presc_latency got %0d want 9..15", lat);
    end
    vectors++;
    if (bus.ocupado[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL presc_busy_start ocupado=%b want 0", bus.ocupado[0]);
    end
  endtask

  initial begin
    test_reset();
`ifdef TIMER_PRESC_EN
    test_presc();
`else
    test_one_shot();
    test_periodic();
    test_abort();
    test_edge_limits();
    test_back_to_back();
    test_reset_mid();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
